// File: rtl/regfile_writeback.sv
`default_nettype none
// regfile_writeback: arbitrates ALU and load results onto the register file write port.
// Loads wait in a DEPTH-entry FIFO; a younger ALU write to the same rd kills the buffered load.
module regfile_writeback #(
    parameter int n     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic         alu_valid,
    input  logic [4:0]   alu_rd,
    input  logic [n-1:0] alu_data,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [4:0]   ld_rd,
    input  logic [n-1:0] ld_data,
    output logic         regw,
    output logic [5:0]   regaddrW,
    output logic [n-1:0] wdata,
    output logic [31:0]  pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] live;
    logic [4:0]       rd_q   [DEPTH];
    logic [n-1:0]     data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic alu_acc;
    logic ld_acc;
    logic enq;
    logic not_empty;
    logic head_live;
    logic pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            bump = '0;
        end else begin
            bump = p + PW'(1);
        end
    endfunction

    assign ld_ready  = (count < CW'(DEPTH));
    assign alu_acc   = alu_valid && (alu_rd != 5'd0);
    assign ld_acc    = ld_valid && ld_ready;
    // A same-cycle ALU write to the same register makes the load stale before it lands.
    assign enq       = ld_acc && (ld_rd != 5'd0) && !(alu_acc && (ld_rd == alu_rd));
    assign not_empty = (count != '0);
    assign head_live = not_empty && live[head];
    // Killed heads drain every cycle; a live head drains only when the ALU leaves the port free.
    assign pop       = not_empty && (!live[head] || !alu_acc);

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
                pend_mask[rd_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            live     <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            regw     <= 1'b0;
            regaddrW <= '0;
            wdata    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (alu_acc) begin
                regw     <= 1'b1;
                regaddrW <= {1'b0, alu_rd};
                wdata    <= alu_data;
            end else if (head_live) begin
                regw     <= 1'b1;
                regaddrW <= {1'b0, rd_q[head]};
                wdata    <= data_q[head];
            end else begin
                regw     <= 1'b0;
            end

            if (alu_acc) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rd_q[i] == alu_rd) begin
                        live[i] <= 1'b0;
                    end
                end
            end

            if (pop) begin
                live[head] <= 1'b0;
                head       <= bump(head);
            end

            if (enq) begin
                live[tail]   <= 1'b1;
                rd_q[tail]   <= ld_rd;
                data_q[tail] <= ld_data;
                tail         <= bump(tail);
            end

            case ({enq, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// Scoreboard bench for regfile_writeback: tasks push expected writes, a negedge monitor pops and compares.
module tb_regfile_writeback;

    logic        clock;
    logic        nreset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        regw;
    logic [5:0]  regaddrW;
    logic [31:0] wdata;
    logic [31:0] pend_mask;

    int assertions = 0;
    int failures   = 0;
    logic [37:0] sb [$];

    regfile_writeback #(.n(32), .DEPTH(2)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .regw      (regw),
        .regaddrW  (regaddrW),
        .wdata     (wdata),
        .pend_mask (pend_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        logic [37:0] exp_w;
        if (nreset && regw) begin
            assertions++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", regaddrW, wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({regaddrW, wdata} !== exp_w) begin
                    failures++;
                    $display("FAIL write_order: got addr=%0d data=%h, required addr=%0d data=%h",
                             regaddrW, wdata, exp_w[37:32], exp_w[31:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
        sb.push_back({1'b0, a, d});
    endtask

    task automatic idle_inputs;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        nreset = 1'b0;
        @(negedge clock);
        assertions++;
        if (regw !== 1'b0 || regaddrW !== 6'd0 || wdata !== 32'd0 || pend_mask !== 32'd0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got regw=%b addr=%0d data=%h pend=%h rdy=%b, required 0/0/0/0/1",
                     regw, regaddrW, wdata, pend_mask, ld_ready);
        end
        tick();
        nreset = 1'b1;
        tick();
        // ALU keeps the port busy so two loads stay buffered, then reset hits mid-cycle.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100; expect_write(5'd1, 32'h100);
        ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'hA2;
        tick();
        alu_data = 32'h101; expect_write(5'd1, 32'h101);
        ld_rd = 5'd3; ld_data = 32'hA3;
        tick();
        assertions++;
        if (pend_mask !== 32'h0000_000C || ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_prefill: got pend=%h rdy=%b, required pend=0000000c rdy=0", pend_mask, ld_ready);
        end
        idle_inputs();
        #2 nreset = 1'b0;
        #1;
        assertions++;
        if (regw !== 1'b0 || pend_mask !== 32'd0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_midburst: got regw=%b pend=%h rdy=%b, required 0/0/1", regw, pend_mask, ld_ready);
        end
        tick();
        nreset = 1'b1;
        repeat (4) tick();
        assertions++;
        if (sb.size() != 0 || pend_mask !== 32'd0) begin
            failures++;
            $display("FAIL reset_discard: got pending_expected=%0d pend=%h, required 0/0", sb.size(), pend_mask);
        end
    endtask

    task automatic test_alu;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; expect_write(5'd5, 32'hDEADBEEF);
        tick();
        assertions++;
        if (regw !== 1'b1 || regaddrW !== 6'd5) begin
            failures++;
            $display("FAIL alu_latency: got regw=%b addr=%0d, required 1/5", regw, regaddrW);
        end
        alu_rd = 5'd0; alu_data = 32'h12345678;
        tick();
        assertions++;
        if (regw !== 1'b0 || regaddrW !== 6'd5 || wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL alu_x0_hold: got regw=%b addr=%0d data=%h, required 0/5/deadbeef", regw, regaddrW, wdata);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load_drain;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11; expect_write(5'd7, 32'h11);
        tick();
        assertions++;
        if (pend_mask !== 32'h0000_0080 || regw !== 1'b0) begin
            failures++;
            $display("FAIL load_pending: got pend=%h regw=%b, required 00000080/0", pend_mask, regw);
        end
        idle_inputs();
        tick();
        assertions++;
        if (regw !== 1'b1 || regaddrW !== 6'd7 || pend_mask !== 32'd0) begin
            failures++;
            $display("FAIL load_drain: got regw=%b addr=%0d pend=%h, required 1/7/00000000", regw, regaddrW, pend_mask);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int   idx = 0;
        logic accepted;
        alu_valid = 1'b1; alu_rd = 5'd1;
        ld_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            alu_data = 32'h300 + c;
            expect_write(5'd1, alu_data);
            ld_rd = 5'(2 + idx); ld_data = 32'h200 + idx;
            accepted = ld_ready;
            tick();
            if (accepted) idx++;
        end
        assertions++;
        if (idx != 2 || ld_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure: got accepts=%0d rdy=%b, required 2/0", idx, ld_ready);
        end
        alu_valid = 1'b0;
        expect_write(5'd2, 32'h200);
        expect_write(5'd3, 32'h201);
        expect_write(5'd4, 32'h202);
        ld_rd = 5'd4; ld_data = 32'h202;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            accepted = ld_ready;
            tick();
            if (accepted) begin
                idx++;
                ld_valid = 1'b0;
            end
        end
        assertions++;
        if (idx != 3) begin
            failures++;
            $display("FAIL third_load_timeout: got accepts=%0d, required 3", idx);
        end
        idle_inputs();
        repeat (4) tick();
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL backpressure_drain: got outstanding=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_kill;
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hAA;
        tick();
        assertions++;
        if (pend_mask !== 32'h0000_0200) begin
            failures++;
            $display("FAIL kill_pending: got pend=%h, required 00000200", pend_mask);
        end
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hBB; expect_write(5'd9, 32'hBB);
        tick();
        assertions++;
        if (pend_mask !== 32'd0) begin
            failures++;
            $display("FAIL kill_clear: got pend=%h, required 00000000", pend_mask);
        end
        idle_inputs();
        tick();
        assertions++;
        if (regw !== 1'b0) begin
            failures++;
            $display("FAIL kill_no_write: got regw=%b addr=%0d data=%h, required regw=0", regw, regaddrW, wdata);
        end
        tick();
        // Same-cycle collision: the load is dropped but its handshake completes.
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hBB; expect_write(5'd9, 32'hBB);
        ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'hAA;
        tick();
        assertions++;
        if (pend_mask !== 32'd0 || ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL kill_same_cycle: got pend=%h rdy=%b, required 00000000/1", pend_mask, ld_ready);
        end
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_ordering;
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h1; expect_write(5'd3, 32'h1);
        tick();
        ld_rd = 5'd4; ld_data = 32'h2; expect_write(5'd4, 32'h2);
        tick();
        idle_inputs();
        assertions++;
        if (regw !== 1'b1 || regaddrW !== 6'd3 || pend_mask !== 32'h0000_0010) begin
            failures++;
            $display("FAIL order_first: got regw=%b addr=%0d pend=%h, required 1/3/00000010", regw, regaddrW, pend_mask);
        end
        tick();
        assertions++;
        if (regw !== 1'b1 || regaddrW !== 6'd4 || wdata !== 32'h2) begin
            failures++;
            $display("FAIL order_second: got regw=%b addr=%0d data=%h, required 1/4/00000002", regw, regaddrW, wdata);
        end
        repeat (3) tick();
    endtask

    initial begin
        idle_inputs();
        nreset = 1'b0;
        test_reset();
        test_alu();
        test_load_drain();
        test_back_to_back();
        test_kill();
        test_ordering();
        assertions++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got outstanding=%0d, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire
